// File: rtl/subt_div_seq.sv
// Iterative unsigned restoring divider built around one shared subt instance.
// A start request in idle latches the operands, then N trial-subtract/shift
// iterations (one per clock) produce quotient and remainder, flagged by a
// one-cycle done pulse. A zero divisor completes immediately with quotient
// all ones, remainder = dividend and div_by_zero set.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start_i       begin a division (sampled only when idle)
//   dividend_i    unsigned dividend, sampled with start_i
//   divisor_i     unsigned divisor, sampled with start_i
//   busy_o        high whenever not idle
//   done_o        one-cycle completion pulse
//   quotient_o    registered quotient, held until next completion
//   remainder_o   registered remainder, held until next completion
//   div_by_zero_o set when the last completed operation had divisor == 0

module subt_div_seq #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] quotient_o,
    output logic [N-1:0] remainder_o,
    output logic         div_by_zero_o
);

    localparam int unsigned CntW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [N-1:0]    r_q, r_d;       // partial remainder
    logic [N-1:0]    q_q, q_d;       // dividend shifting out, quotient shifting in
    logic [N-1:0]    d_q, d_d;       // latched divisor
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    quot_q, quot_d;
    logic [N-1:0]    rem_q, rem_d;
    logic            dbz_q, dbz_d;

    logic [N:0] trial;
    logic [N:0] sub_b;
    logic [N:0] sub_diff;
    logic       sub_cout;
    logic       sub_neg;
    logic       last_iter;

    // Trial value: remainder shifted left with the next dividend bit brought in.
    assign trial     = {r_q, q_q[N-1]};
    assign sub_b     = {1'b0, d_q};
    assign last_iter = (cnt_q == CntW'(1));

    subt #(
        .W(N + 1)
    ) u_subt (
        .a_i   (trial),
        .b_i   (sub_b),
        .cin_i (1'b1),
        .diff_o(sub_diff),
        .cout_o(sub_cout),
        .neg_o (sub_neg)
    );

    // Top difference bit is always 0 when kept (R < D invariant); neg is not needed.
    logic unused_sub;
    assign unused_sub = ^{sub_neg, sub_diff[N]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = (divisor_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (last_iter) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs, decoded from registered state only
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        unique case (state_q)
            StIdle:  busy_o = 1'b0;
            StRun:   busy_o = 1'b1;
            StDone: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: busy_o = 1'b0;
        endcase
    end

    // Datapath next-state
    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        d_d    = d_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (divisor_i == '0) begin
                        quot_d = '1;
                        rem_d  = dividend_i;
                        dbz_d  = 1'b1;
                    end else begin
                        d_d   = divisor_i;
                        q_d   = dividend_i;
                        r_d   = '0;
                        cnt_d = CntW'(N);
                    end
                end
            end
            StRun: begin
                // cout = 1 means no borrow: trial >= divisor, keep the difference.
                r_d   = sub_cout ? sub_diff[N-1:0] : trial[N-1:0];
                q_d   = {q_q[N-2:0], sub_cout};
                cnt_d = cnt_q - CntW'(1);
                if (last_iter) begin
                    quot_d = q_d;
                    rem_d  = r_d;
                    dbz_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            d_q    <= d_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// Combinational W-bit subtractor: diff = a + ~b + cin, so with cin = 1 it is a - b.
// cout_o = 1 means no borrow (a >= b unsigned); neg_o is its complement.
module subt #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] diff_o,
    output logic         cout_o,
    output logic         neg_o
);

    logic [W:0] sum;

    assign sum    = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, cin_i};
    assign diff_o = sum[W-1:0];
    assign cout_o = sum[W];
    assign neg_o  = ~sum[W];

endmodule

// File: tb/tb_subt_div_seq.sv
// Self-checking bench for subt_div_seq: directed N=4 scenarios (basic, sweep,
// divide by zero, start while busy, asynchronous reset abort) followed by
// 1000 random N=8 divisions checked against plain / and % arithmetic.

module tb_subt_div_seq;

    logic clk;
    logic rst_n;

    logic       start4;
    logic [3:0] dvd4, dvs4, quo4, rem4;
    logic       busy4, done4, dbz4;

    logic       start8;
    logic [7:0] dvd8, dvs8, quo8, rem8;
    logic       busy8, done8, dbz8;

    int checks = 0;
    int errors = 0;

    subt_div_seq #(.N(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start4),
        .dividend_i   (dvd4),
        .divisor_i    (dvs4),
        .busy_o       (busy4),
        .done_o       (done4),
        .quotient_o   (quo4),
        .remainder_o  (rem4),
        .div_by_zero_o(dbz4)
    );

    subt_div_seq #(.N(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start8),
        .dividend_i   (dvd8),
        .divisor_i    (dvs8),
        .busy_o       (busy8),
        .done_o       (done8),
        .quotient_o   (quo8),
        .remainder_o  (rem8),
        .div_by_zero_o(dbz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic, with the zero-divisor convention.
    function automatic logic [15:0] ref_div(input int unsigned a, input int unsigned b,
                                            input int unsigned w);
        int unsigned q, r;
        if (b == 0) begin
            q = (1 << w) - 1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q[7:0], r[7:0]};
    endfunction

    // One complete N=4 operation: latency, result, flag, hold after done.
    task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b);
        logic [15:0] e;
        int n;
        e = ref_div(a, b, 4);
        @(negedge clk);
        start4 = 1'b1; dvd4 = a; dvs4 = b;
        @(posedge clk); #1;
        start4 = 1'b0;
        dvd4 = 4'($urandom); dvs4 = 4'($urandom);  // must not disturb the result
        n = 0;
        while (!done4 && n < 30) begin
            chk({tag, "_busy"}, busy4, 1);
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, n, (b == 0) ? 0 : 4);
        chk({tag, "_q"}, quo4, e[15:8]);
        chk({tag, "_r"}, rem4, e[7:0]);
        chk({tag, "_dbz"}, dbz4, (b == 0) ? 1 : 0);
        @(posedge clk); #1;
        chk({tag, "_done_fall"}, {busy4, done4}, 0);
        chk({tag, "_q_hold"}, quo4, e[15:8]);
        chk({tag, "_r_hold"}, rem4, e[7:0]);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] e;
        int n;
        e = ref_div(a, b, 8);
        @(negedge clk);
        start8 = 1'b1; dvd8 = a; dvs8 = b;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("n8_lat", n, (b == 0) ? 0 : 8);
        chk("n8_q", quo8, e[15:8]);
        chk("n8_r", rem8, e[7:0]);
        chk("n8_dbz", dbz8, (b == 0) ? 1 : 0);
        @(posedge clk); #1;
        chk("n8_idle", {busy8, done8}, 0);
    endtask

    initial begin
        int pulses;
        logic [3:0] cq, cr;

        rst_n = 1'b0;
        start4 = 1'b0; dvd4 = '0; dvs4 = '0;
        start8 = 1'b0; dvd8 = '0; dvs8 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_done", {busy4, done4, busy8, done8}, 0);
        chk("rst_q_r_dbz", {quo4, rem4, dbz4}, 0);
        chk("rst_n8", {quo8, rem8, dbz8}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic operation, then sweep of results that must hold between completions
        op4("d13_3", 4'd13, 4'd3);
        op4("d15_1", 4'd15, 4'd1);
        op4("d5_7", 4'd5, 4'd7);
        op4("d8_8", 4'd8, 4'd8);
        op4("d0_15", 4'd0, 4'd15);

        // Divide by zero, then a normal op clears the flag
        op4("d9_0", 4'd9, 4'd0);
        op4("d6_2", 4'd6, 4'd2);

        // Start while busy is ignored: 14/3 runs, 1/1 two cycles later is dropped
        @(negedge clk);
        start4 = 1'b1; dvd4 = 4'd14; dvs4 = 4'd3;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        start4 = 1'b1; dvd4 = 4'd1; dvs4 = 4'd1;
        @(negedge clk);
        start4 = 1'b0;
        pulses = 0; cq = '0; cr = '0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done4) begin
                pulses++;
                cq = quo4;
                cr = rem4;
            end
        end
        chk("busy_ign_pulses", pulses, 1);
        chk("busy_ign_q", cq, 4);
        chk("busy_ign_r", cr, 2);

        // Asynchronous reset in the third RUN cycle aborts with no done pulse
        @(negedge clk);
        start4 = 1'b1; dvd4 = 4'd15; dvs4 = 4'd2;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_outs", {busy4, done4, quo4, rem4, dbz4}, 0);
        pulses = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done4 || busy4) pulses++;
        end
        chk("abort_quiet", pulses, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op4("d10_4", 4'd10, 4'd4);

        // Random N=8 against the arithmetic reference
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            op8(a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
